ram_fifo_ctrl: RTL and testbench

//  Upstream controller that turns the single-port 4x4 RAM (ram_4x4) into a 5-deep show-ahead FIFO.
//  It arbitrates writes and head-prefetch reads onto the single RAM port, one access per cycle.
//  It also keeps a 1-entry output register that bypasses the RAM when the FIFO is empty.
//  The parent instantiates this block next to ram_4x4 and wires the ram_* ports straight across.

---
 rtl/ram_fifo_ctrl_pkg.sv | 20 ++
 rtl/ram_fifo_ctrl.sv | 106 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and types for the RAM-backed show-ahead FIFO controller.
package ram_fifo_ctrl_pkg;

   localparam int FIFO_DATA_W = 4;
   localparam int FIFO_ADDR_W = 2;
   localparam int FIFO_DEPTH  = 4;

   // RAM rdwr encoding: writes commit on the clock edge, reads are combinational.
   localparam logic RAM_RD = 1'b1;
   localparam logic RAM_WR = 1'b0;

   // One RAM-port use per cycle; listed in arbitration priority order.
   typedef enum logic [1:0] {
      MODE_IDLE,
      MODE_READ,
      MODE_BYPASS,
      MODE_WRITE
   } mode_e;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// Turns a single-port RAM into a DEPTH+1 show-ahead FIFO: the RAM holds the
// tail, a 1-entry output register holds the head. Head prefetch reads take
// priority over writes; a push into an empty FIFO bypasses the RAM entirely.
module ram_fifo_ctrl
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W,
   parameter int ADDR_W = FIFO_ADDR_W,
   parameter int DEPTH  = FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_valid,
   input  logic [DATA_W-1:0]             wr_data,
   output logic                          wr_ready,
   output logic                          rd_valid,
   output logic [DATA_W-1:0]             rd_data,
   input  logic                          rd_ready,
   output logic [$clog2(DEPTH+2)-1:0]    count,
   output logic                          full,
   output logic                          empty,
   output logic [DATA_W-1:0]             ram_data_in,
   output logic [ADDR_W-1:0]             ram_ad_in,
   output logic                          ram_en,
   output logic                          ram_rdwr,
   input  logic [DATA_W-1:0]             ram_data_out
);

   localparam int CNT_W = $clog2(DEPTH+2);

   logic [ADDR_W-1:0] wp, rp;
   logic [CNT_W-1:0]  ram_cnt;
   logic              pop, slot_free, prefetch, push, bypass;
   mode_e             mode;

   // Handshake decode and single-port arbitration.
   always_comb begin
      pop       = rd_valid & rd_ready;
      slot_free = ~rd_valid | pop;
      prefetch  = slot_free & (ram_cnt != '0);
      // Depends on rd_ready but never on wr_valid, so no comb loop with the producer.
      wr_ready  = ~prefetch & (ram_cnt != CNT_W'(DEPTH));
      push      = wr_valid & wr_ready;
      bypass    = push & slot_free & (ram_cnt == '0);

      mode = MODE_IDLE;
      if (prefetch)    mode = MODE_READ;
      else if (bypass) mode = MODE_BYPASS;
      else if (push)   mode = MODE_WRITE;

      ram_data_in = wr_data;
      ram_en      = 1'b0;
      ram_rdwr    = RAM_RD;
      ram_ad_in   = rp;
      case (mode)
         MODE_READ: begin
            ram_en = 1'b1;
         end
         MODE_WRITE: begin
            ram_en    = 1'b1;
            ram_rdwr  = RAM_WR;
            ram_ad_in = wp;
         end
         default: ;
      endcase
   end

   // Pointer, RAM occupancy and output-register update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp       <= '0;
         rp       <= '0;
         ram_cnt  <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         // A pop empties the slot unless a refill below lands in the same edge.
         if (pop) rd_valid <= 1'b0;
         case (mode)
            MODE_READ: begin
               rd_data  <= ram_data_out;
               rd_valid <= 1'b1;
               rp       <= (rp == ADDR_W'(DEPTH-1)) ? '0 : rp + 1'b1;
               ram_cnt  <= ram_cnt - 1'b1;
            end
            MODE_BYPASS: begin
               rd_data  <= wr_data;
               rd_valid <= 1'b1;
            end
            MODE_WRITE: begin
               wp      <= (wp == ADDR_W'(DEPTH-1)) ? '0 : wp + 1'b1;
               ram_cnt <= ram_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // The head register is always filled before the RAM, so empty == ~rd_valid.
   always_comb begin
      count = ram_cnt + {{(CNT_W-1){1'b0}}, rd_valid};
      full  = (count == CNT_W'(DEPTH+1));
      empty = ~rd_valid;
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed and random checks of ram_fifo_ctrl against a behavioural 4x4 RAM
// and a queue reference model.
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_valid, wr_ready, rd_valid, rd_ready;
   logic [3:0] wr_data, rd_data;
   logic [2:0] count;
   logic       full, empty;
   logic [3:0] ram_data_in, ram_data_out;
   logic [1:0] ram_ad_in;
   logic       ram_en, ram_rdwr;

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] model_q[$];

   always #5 clk = ~clk;

   ram_fifo_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
      .count(count), .full(full), .empty(empty),
      .ram_data_in(ram_data_in), .ram_ad_in(ram_ad_in),
      .ram_en(ram_en), .ram_rdwr(ram_rdwr), .ram_data_out(ram_data_out)
   );

   // Behavioural single-port RAM: combinational read, edge write.
   logic [3:0] mem [4];
   assign ram_data_out = mem[ram_ad_in];
   always @(posedge clk) if (ram_en && !ram_rdwr) mem[ram_ad_in] <= ram_data_in;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      #12;
      n_checks++; if (rd_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || ram_en !== 1'b0 || wr_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_init: rd_valid=%b count=%0d empty=%b ram_en=%b wr_ready=%b, want 0 0 1 0 1",
                            rd_valid, count, empty, ram_en, wr_ready);
      end
      @(negedge clk); rst_n = 1'b1;
      tick();
      // push three words, then reset mid-cycle with a write in flight
      wr_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin wr_data = 4'(i); tick(); end
      wr_data = 4'h7;
      #1;
      n_checks++; if (count !== 3'd3 || ram_en !== 1'b1) begin
         n_fail++; $display("FAIL reset_prefill: count=%0d ram_en=%b, want 3 1", count, ram_en);
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (rd_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || ram_en !== 1'b0) begin
         n_fail++; $display("FAIL reset_async: rd_valid=%b count=%0d empty=%b ram_en=%b, want 0 0 1 0",
                            rd_valid, count, empty, ram_en);
      end
      wr_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      tick();
      n_checks++; if (count !== 3'd0 || full !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: count=%0d full=%b, want 0 0", count, full);
      end
   endtask

   task automatic test_bypass();
      wr_valid = 1'b1; wr_data = 4'hA; rd_ready = 1'b0;
      #1;
      n_checks++; if (ram_en !== 1'b0 || wr_ready !== 1'b1) begin
         n_fail++; $display("FAIL bypass_noram: ram_en=%b wr_ready=%b, want 0 1", ram_en, wr_ready);
      end
      tick();
      wr_valid = 1'b0;
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== 4'hA || count !== 3'd1) begin
         n_fail++; $display("FAIL bypass_head: rd_valid=%b rd_data=%h count=%0d, want 1 a 1", rd_valid, rd_data, count);
      end
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
      n_checks++; if (empty !== 1'b1) begin
         n_fail++; $display("FAIL bypass_drain: empty=%b, want 1", empty);
      end
   endtask

   task automatic test_fill();
      rd_ready = 1'b0; wr_valid = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         wr_data = 4'(i);
         #1;
         if (i == 1) begin
            n_checks++; if (ram_en !== 1'b0) begin
               n_fail++; $display("FAIL fill_bypass: ram_en=%b, want 0", ram_en);
            end
         end else begin
            n_checks++; if (ram_en !== 1'b1 || ram_rdwr !== 1'b0 || ram_ad_in !== 2'(i-2) || ram_data_in !== 4'(i)) begin
               n_fail++; $display("FAIL fill_write%0d: en=%b rdwr=%b ad=%0d din=%h, want 1 0 %0d %h",
                                  i, ram_en, ram_rdwr, ram_ad_in, ram_data_in, i-2, i);
            end
         end
         tick();
      end
      wr_data = 4'h6;
      #1;
      n_checks++; if (full !== 1'b1 || wr_ready !== 1'b0 || count !== 3'd5 || ram_en !== 1'b0) begin
         n_fail++; $display("FAIL fill_full: full=%b wr_ready=%b count=%0d ram_en=%b, want 1 0 5 0", full, wr_ready, count, ram_en);
      end
      rd_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         #1;
         n_checks++; if (rd_data !== 4'(i) || rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL fill_pop%0d: rd_data=%h rd_valid=%b, want %h 1", i, rd_data, rd_valid, i);
         end
         if (i <= 4) begin
            n_checks++; if (wr_ready !== 1'b0 || ram_en !== 1'b1 || ram_rdwr !== 1'b1 || ram_ad_in !== 2'(i-1)) begin
               n_fail++; $display("FAIL fill_prefetch%0d: wr_ready=%b en=%b rdwr=%b ad=%0d, want 0 1 1 %0d",
                                  i, wr_ready, ram_en, ram_rdwr, ram_ad_in, i-1);
            end
         end
         wr_valid = 1'b0;
         tick();
      end
      rd_ready = 1'b0;
      n_checks++; if (empty !== 1'b1 || count !== 3'd0) begin
         n_fail++; $display("FAIL fill_empty: empty=%b count=%0d, want 1 0", empty, count);
      end
   endtask

   // After test_fill both pointers have wrapped back to 0.
   task automatic test_simultaneous();
      wr_valid = 1'b1; rd_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin wr_data = 4'(i); tick(); end
      wr_data = 4'h9; rd_ready = 1'b1;
      #1;
      n_checks++; if (count !== 3'd3 || wr_ready !== 1'b0 || ram_en !== 1'b1 || ram_rdwr !== 1'b1 || ram_ad_in !== 2'd0) begin
         n_fail++; $display("FAIL simul_readwins: count=%0d wr_ready=%b en=%b rdwr=%b ad=%0d, want 3 0 1 1 0",
                            count, wr_ready, ram_en, ram_rdwr, ram_ad_in);
      end
      tick();
      rd_ready = 1'b0;
      #1;
      n_checks++; if (rd_data !== 4'h2 || count !== 3'd2 || wr_ready !== 1'b1 || ram_en !== 1'b1 || ram_rdwr !== 1'b0 || ram_ad_in !== 2'd2) begin
         n_fail++; $display("FAIL simul_retry: rd_data=%h count=%0d wr_ready=%b en=%b rdwr=%b ad=%0d, want 2 2 1 1 0 2",
                            rd_data, count, wr_ready, ram_en, ram_rdwr, ram_ad_in);
      end
      tick();
      wr_valid = 1'b0;
      n_checks++; if (count !== 3'd3) begin
         n_fail++; $display("FAIL simul_landed: count=%0d, want 3", count);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (rd_data !== (i == 0 ? 4'h2 : (i == 1 ? 4'h3 : 4'h9))) begin
            n_fail++; $display("FAIL simul_drain%0d: rd_data=%h", i, rd_data);
         end
         tick();
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_wrap();
      int burst [3] = '{3, 5, 4};
      int v = 0;
      for (int b = 0; b < 3; b++) begin
         rd_ready = 1'b0; wr_valid = 1'b1;
         for (int k = 0; k < burst[b]; k++) begin
            wr_data = 4'((v * 7 + 3) & 15); model_q.push_back(wr_data); v++;
            tick();
         end
         wr_valid = 1'b0; rd_ready = 1'b1;
         for (int k = 0; k < burst[b]; k++) begin
            #1;
            n_checks++; if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
               n_fail++; $display("FAIL wrap_b%0d_k%0d: rd_valid=%b rd_data=%h, want 1 %h", b, k, rd_valid, rd_data, model_q[0]);
            end
            void'(model_q.pop_front());
            tick();
         end
      end
      rd_ready = 1'b0;
      n_checks++; if (empty !== 1'b1) begin
         n_fail++; $display("FAIL wrap_empty: empty=%b, want 1", empty);
      end
   endtask

   task automatic test_random();
      int sz;
      logic exp_wr_ready;
      model_q.delete();
      for (int c = 0; c < 2000; c++) begin
         wr_valid = 1'($urandom_range(0, 1));
         rd_ready = 1'($urandom_range(0, 1));
         wr_data  = 4'($urandom_range(0, 15));
         #1;
         sz = model_q.size();
         exp_wr_ready = !(rd_ready && sz > 1) && sz != 5;
         n_checks++; if (count !== 3'(sz) || rd_valid !== (sz != 0) || wr_ready !== exp_wr_ready || sz > 5) begin
            n_fail++; $display("FAIL rand_state c%0d: count=%0d rd_valid=%b wr_ready=%b, want %0d %b %b",
                               c, count, rd_valid, wr_ready, sz, sz != 0, exp_wr_ready);
         end
         if (rd_valid && rd_ready && sz != 0) begin
            n_checks++; if (rd_data !== model_q[0]) begin
               n_fail++; $display("FAIL rand_data c%0d: rd_data=%h, want %h", c, rd_data, model_q[0]);
            end
            void'(model_q.pop_front());
         end
         if (wr_valid && exp_wr_ready) model_q.push_back(wr_data);
         tick();
      end
      wr_valid = 1'b0; rd_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_fill();
      test_simultaneous();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
